// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Contents: op bit indices within the 5-bit mul/div/rem slice (and where that
// slice sits in the ALU control vector), FSM state encoding, decoded
// operation kind, and the default data width.
package mdu_pkg;

    localparam int XLEN_DEF     = 64;
    localparam int MDU_CTRL_OFS = 17;  // bit 0 of op == ALU ctrl bit 17

    localparam int MDU_MUL  = 0;
    localparam int MDU_DIV  = 1;
    localparam int MDU_DIVU = 2;
    localparam int MDU_REM  = 3;
    localparam int MDU_REMU = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_MUL  = 3'd1,
        K_DIV  = 3'd2,
        K_DIVU = 3'd3,
        K_REM  = 3'd4,
        K_REMU = 3'd5
    } mdu_kind_e;

    // Multi-hot op vectors resolve to the lowest set bit.
    function automatic mdu_kind_e pick_op(input logic [4:0] op);
        if (op[MDU_MUL])       return K_MUL;
        else if (op[MDU_DIV])  return K_DIV;
        else if (op[MDU_DIVU]) return K_DIVU;
        else if (op[MDU_REM])  return K_REM;
        else if (op[MDU_REMU]) return K_REMU;
        else                   return K_NONE;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the issue stage, the multiply/divide unit
// and the writeback mux.
//   master : issue/writeback side (drives request, flush, out_ready)
//   slave  : the unit (drives in_ready, out_valid, result, busy)
interface mdu_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic            is_word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, is_word, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, is_word, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Ports:
//   rem_in   partial remainder (always < divisor)
//   dvd_msb  top bit of the dividend shift register, shifted in this step
//   divisor  divisor magnitude
//   rem_out  next partial remainder
//   q_bit    quotient bit produced by this step
module mdu_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_msb};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end
endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide responder, one bit per clock.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   bus        mdu_if slave: request (in_valid/in_ready, op, is_word, src1,
//              src2), flush, response (out_valid/out_ready, result), busy
//
// state   | meaning
// IDLE    | ready to accept a request
// CALC    | iterating (or one pass to publish a special-case result)
// DONE    | result valid, waiting for out_ready
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    mdu_state_e      state_q, state_d;
    mdu_kind_e       kind_q;
    logic            word_q, neg_quo_q, neg_rem_q, spec_q, out_valid_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] a_q, b_q, acc_q, result_q;

    logic accept;
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;

    // ---------------- request decode ----------------
    mdu_kind_e       kind_in;
    logic            sgn_in, divl_in, is_div_in, s1_neg, s2_neg;
    logic            zero_div, ovf, special;
    logic [XLEN-1:0] s1x, s2x, m1, m2, min_val, spec_res;

    always_comb begin
        kind_in   = pick_op(bus.op);
        sgn_in    = (kind_in == K_DIV) || (kind_in == K_REM);
        is_div_in = (kind_in == K_DIV) || (kind_in == K_DIVU);
        divl_in   = is_div_in || (kind_in == K_REM) || (kind_in == K_REMU);

        if (bus.is_word) begin
            s1x = sgn_in ? sext32(bus.src1[31:0]) : {{(XLEN-32){1'b0}}, bus.src1[31:0]};
            s2x = sgn_in ? sext32(bus.src2[31:0]) : {{(XLEN-32){1'b0}}, bus.src2[31:0]};
        end else begin
            s1x = bus.src1;
            s2x = bus.src2;
        end

        s1_neg = sgn_in & s1x[XLEN-1];
        s2_neg = sgn_in & s2x[XLEN-1];
        m1     = s1_neg ? -s1x : s1x;
        m2     = s2_neg ? -s2x : s2x;

        // Most negative value of the selected width, already sign-extended.
        min_val  = bus.is_word ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN-1));
        zero_div = divl_in && (s2x == '0);
        ovf      = sgn_in && (s1x == min_val) && (s2x == '1);
        special  = (kind_in == K_NONE) || zero_div || ovf;

        spec_res = '0;
        if (zero_div)
            spec_res = is_div_in ? '1 : (bus.is_word ? sext32(bus.src1[31:0]) : bus.src1);
        else if (ovf)
            spec_res = is_div_in ? s1x : '0;
    end

    // ---------------- iteration datapath ----------------
    logic            is_mul_q, is_div_q, q_bit;
    logic [XLEN-1:0] rem_nx, a_nx, b_nx, acc_nx, quo_fix, rem_fix, raw, res_final;

    assign is_mul_q = (kind_q == K_MUL);
    assign is_div_q = (kind_q == K_DIV) || (kind_q == K_DIVU);

    mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (acc_q),
        .dvd_msb (a_q[XLEN-1]),
        .divisor (b_q),
        .rem_out (rem_nx),
        .q_bit   (q_bit)
    );

    always_comb begin
        if (is_mul_q) begin
            acc_nx = acc_q + (b_q[0] ? a_q : '0);
            a_nx   = a_q << 1;
            b_nx   = b_q >> 1;
        end else begin
            // Quotient bits enter the dividend register as it drains.
            acc_nx = rem_nx;
            a_nx   = {a_q[XLEN-2:0], q_bit};
            b_nx   = b_q;
        end
        quo_fix   = neg_quo_q ? -a_nx : a_nx;
        rem_fix   = neg_rem_q ? -rem_nx : rem_nx;
        raw       = is_mul_q ? acc_nx : (is_div_q ? quo_fix : rem_fix);
        res_final = word_q ? sext32(raw[31:0]) : raw;
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CALC;
            ST_CALC: if (spec_q || cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q    <= K_NONE;
            word_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            spec_q    <= 1'b0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            kind_q    <= kind_in;
            word_q    <= bus.is_word;
            neg_quo_q <= s1_neg ^ s2_neg;
            neg_rem_q <= s1_neg;
            spec_q    <= special;
            cnt_q     <= bus.is_word ? CW'(31) : CW'(XLEN-1);
            // Word dividends are left-aligned so 32 steps consume them fully.
            a_q       <= (kind_in == K_MUL) ? s1x : (bus.is_word ? (m1 << (XLEN-32)) : m1);
            b_q       <= (kind_in == K_MUL) ? s2x : m2;
            acc_q     <= special ? spec_res : '0;
        end else if (state_q == ST_CALC && !bus.flush) begin
            if (spec_q) begin
                result_q <= acc_q;
            end else begin
                a_q   <= a_nx;
                b_q   <= b_nx;
                acc_q <= acc_nx;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == '0) result_q <= res_final;
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: latency, results, special cases, back-pressure,
// flush and mid-operation reset.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam logic [4:0] OP_MUL  = 5'b00001;
    localparam logic [4:0] OP_DIV  = 5'b00010;
    localparam logic [4:0] OP_DIVU = 5'b00100;
    localparam logic [4:0] OP_REM  = 5'b01000;
    localparam logic [4:0] OP_REMU = 5'b10000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_if #(.XLEN(64)) bus();
    mdu_seq #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Present a request at the negedge; it is accepted on the next posedge.
    task automatic issue(input logic [4:0] op, input logic word,
                         input logic [63:0] s1, input logic [63:0] s2);
        @(negedge clk);
        bus.op       = op;
        bus.is_word  = word;
        bus.src1     = s1;
        bus.src2     = s2;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 200);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic word,
                          input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] exp, input int lat);
        int n;
        check({tag, "_rdy"}, bus.in_ready, 1'b1);
        issue(op, word, s1, s2);
        wait_valid(n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_res"}, bus.result, exp);
        @(posedge clk);
        #1;
        check({tag, "_ovl0"}, bus.out_valid, 1'b0);
        check({tag, "_idle"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        int  n;
        logic saw;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.is_word   = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ovl", bus.out_valid, 1'b0);
        check("rst_res", bus.result, 64'd0);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rdy", bus.in_ready, 1'b1);

        run_op("div100_7", OP_DIV, 1'b0, 64'd100, 64'd7, 64'd14, 64);
        run_op("rem100_7", OP_REM, 1'b0, 64'd100, 64'd7, 64'd2, 64);
        run_op("divm7_2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
        run_op("remm7_2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run_op("divu_z", OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_z", OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        run_op("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("divw", OP_DIV, 1'b1, 64'h0000_0000_9876_5432, 64'd5, 64'hFFFF_FFFF_EB4A_DDA4, 32);
        run_op("remw", OP_REM, 1'b1, 64'h0000_0000_9876_5432, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 32);
        run_op("op_none", 5'b00000, 1'b0, 64'd9, 64'd3, 64'd0, 1);
        // mul and div both set: mul (bit 0) wins; 6*7 = 42.
        run_op("multihot", OP_MUL | OP_DIV, 1'b0, 64'd6, 64'd7, 64'd42, 64);

        // Back-pressure on a multiply.
        bus.out_ready = 1'b0;
        issue(OP_MUL, 1'b0, 64'h0000_0001_0000_0001, 64'd3);
        wait_valid(n);
        check("mul_lat", n, 64);
        check("mul_res", bus.result, 64'h0000_0003_0000_0003);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_res", bus.result, 64'h0000_0003_0000_0003);
            check("bp_ovl", bus.out_valid, 1'b1);
            check("bp_rdy", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ovl0", bus.out_valid, 1'b0);
        check("bp_idle", bus.in_ready, 1'b1);

        // Flush mid-divide while a new request is presented.
        issue(OP_DIV, 1'b0, 64'd100, 64'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.src1     = 64'd50;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_rdy", bus.in_ready, 1'b1);
        check("fl_ovl", bus.out_valid, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || bus.busy) saw = 1'b1;
        end
        check("fl_quiet", saw, 1'b0);
        run_op("post_fl", OP_DIV, 1'b0, 64'd100, 64'd7, 64'd14, 64);

        // Reset in the middle of a multiply.
        issue(OP_MUL, 1'b0, 64'd5, 64'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_ovl", bus.out_valid, 1'b0);
        check("mrst_res", bus.result, 64'd0);
        check("mrst_rdy", bus.in_ready, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) saw = 1'b1;
        end
        check("mrst_quiet", saw, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
